ram_port_arbiter: RTL and testbench

Shares the single read port (port B) of the synth's dual-port RAM among up to NUM_REQ independent readers, such as the key-state reader, the sound-sample reader and a display/debug reader. Each requester raises a request with an address; the arbiter grants one requester at a time, drives `Address_B`, waits out the RAM's synchronous read latency, and returns the word with a one-cycle valid strobe. It sits between the RAM's port B and the readers, replacing hard-wired address ping-ponging.

---
 rtl/ram_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares the synchronous read port (port B) of the dual-port RAM among
// NUM_REQ readers. One read is serviced at a time through a four-state
// sequence: IDLE -> ADDR -> WAIT -> DONE. The RAM samples Address_B in ADDR,
// its data is valid in WAIT, and the captured word is returned with a
// one-cycle rd_valid strobe.
//
// Build option:
//   RAM_ARB_FIXED_PRIORITY_EN - when defined, the lowest-index asserted
//   request always wins and no round-robin pointer exists. When undefined
//   (default), arbitration is round-robin starting at the pointer.

module ram_port_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        grant,
   output logic [NUM_REQ-1:0]        rd_valid,
   output logic [DATA_W-1:0]         rd_data,
   output logic [ADDR_W-1:0]         Address_B,
   input  logic [DATA_W-1:0]         data_b
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t              state_r;
   state_t              state_s;
   logic [IDX_W-1:0]    winner_r;
   logic [IDX_W-1:0]    winner_s;
   logic [NUM_REQ-1:0]  grant_s;
   logic [NUM_REQ-1:0]  rd_valid_s;
   logic [DATA_W-1:0]   rd_data_s;
   logic [ADDR_W-1:0]   addr_b_s;

   // Arbitration result for the current cycle
   logic                sel_found_s;
   logic [IDX_W-1:0]    sel_idx_s;
   logic [ADDR_W-1:0]   sel_addr_s;
   logic [NUM_REQ-1:0]  sel_onehot_s;

`ifndef RAM_ARB_FIXED_PRIORITY_EN
   logic [IDX_W-1:0]    ptr_r;
   logic [IDX_W-1:0]    ptr_s;
`endif

`ifdef RAM_ARB_FIXED_PRIORITY_EN
   // Fixed priority: scan high to low so the lowest asserted index is written last
   always_comb begin
      sel_found_s = |req;
      sel_idx_s   = {IDX_W{1'b0}};
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[k]) begin
            sel_idx_s = IDX_W'(k);
         end else begin
            sel_idx_s = sel_idx_s;
         end
      end
   end
`else
   // Round-robin: scan offsets high to low so the first asserted index at or after ptr wins
   always_comb begin
      sel_found_s = |req;
      sel_idx_s   = {IDX_W{1'b0}};
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[(int'(ptr_r) + k) % NUM_REQ]) begin
            sel_idx_s = IDX_W'((int'(ptr_r) + k) % NUM_REQ);
         end else begin
            sel_idx_s = sel_idx_s;
         end
      end
   end
`endif

   // Address mux and one-hot decode of the selected requester
   always_comb begin
      sel_addr_s   = {ADDR_W{1'b0}};
      sel_onehot_s = {NUM_REQ{1'b0}};
      for (int k = 0; k < NUM_REQ; k++) begin
         if (sel_idx_s == IDX_W'(k)) begin
            sel_addr_s      = req_addr[k*ADDR_W +: ADDR_W];
            sel_onehot_s[k] = 1'b1;
         end else begin
            sel_onehot_s[k] = 1'b0;
         end
      end
   end

   // Next-state and next-output logic of the transaction sequencer
   always_comb begin
      state_s    = state_r;
      winner_s   = winner_r;
      grant_s    = grant;
      rd_valid_s = rd_valid;
      rd_data_s  = rd_data;
      addr_b_s   = Address_B;
`ifndef RAM_ARB_FIXED_PRIORITY_EN
      ptr_s      = ptr_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (sel_found_s) begin
               winner_s = sel_idx_s;
               grant_s  = sel_onehot_s;
               addr_b_s = sel_addr_s;
               state_s  = ST_ADDR;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_ADDR: begin
            // RAM samples Address_B on this edge
            state_s = ST_WAIT;
         end
         ST_WAIT: begin
            // RAM output is valid now; grant already marks the winner
            rd_data_s  = data_b;
            rd_valid_s = grant;
            state_s    = ST_DONE;
         end
         ST_DONE: begin
            rd_valid_s = {NUM_REQ{1'b0}};
            grant_s    = {NUM_REQ{1'b0}};
`ifndef RAM_ARB_FIXED_PRIORITY_EN
            if (winner_r == IDX_W'(NUM_REQ - 1)) begin
               ptr_s = {IDX_W{1'b0}};
            end else begin
               ptr_s = winner_r + IDX_W'(1);
            end
`endif
            state_s    = ST_IDLE;
         end
         default: begin
            rd_valid_s = {NUM_REQ{1'b0}};
            grant_s    = {NUM_REQ{1'b0}};
            state_s    = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any read in flight
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= ST_IDLE;
         winner_r  <= {IDX_W{1'b0}};
         grant     <= {NUM_REQ{1'b0}};
         rd_valid  <= {NUM_REQ{1'b0}};
         rd_data   <= {DATA_W{1'b0}};
         Address_B <= {ADDR_W{1'b0}};
      end else begin
         state_r   <= state_s;
         winner_r  <= winner_s;
         grant     <= grant_s;
         rd_valid  <= rd_valid_s;
         rd_data   <= rd_data_s;
         Address_B <= addr_b_s;
      end
   end

`ifndef RAM_ARB_FIXED_PRIORITY_EN
   // Round-robin pointer register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr_r <= {IDX_W{1'b0}};
      end else begin
         ptr_r <= ptr_s;
      end
   end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a RAM model on port B and a
// scoreboard of expected (requester, word) pairs checked on every rd_valid.

module tb_ram_port_arbiter;

   localparam int NR = 4;
   localparam int AW = 16;
   localparam int DW = 16;

   logic              clock = 1'b0;
   logic              reset_n;
   logic [NR-1:0]     req;
   logic [NR*AW-1:0]  req_addr;
   logic [NR-1:0]     grant;
   logic [NR-1:0]     rd_valid;
   logic [DW-1:0]     rd_data;
   logic [AW-1:0]     Address_B;
   logic [DW-1:0]     data_b;

   typedef struct packed {
      logic [NR-1:0] who;
      logic [DW-1:0] data;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [DW-1:0] mem [0:255];
   logic [NR-1:0] seq5 [0:4];
   logic [NR-1:0] seq3 [0:2];

   ram_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req       (req),
      .req_addr  (req_addr),
      .grant     (grant),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .Address_B (Address_B),
      .data_b    (data_b)
   );

   always #5 clock = ~clock;

   // Synchronous-read RAM: word appears one clock after the address is sampled
   always @(posedge clock) data_b <= mem[Address_B[7:0]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor: every rd_valid pulse must match the oldest expectation
   always @(negedge clock) begin
      if (reset_n === 1'b1 && rd_valid !== '0) begin
         n_tests++;
         assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_rd_valid: observed %b, expected no pulse", rd_valid);
         end
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("sb_requester", 32'(rd_valid), 32'(mon_e.who));
            check("sb_data", 32'(rd_data), 32'(mon_e.data));
         end
      end
   end

   task automatic set_req(input int i, input logic v, input logic [AW-1:0] a);
      req[i] = v;
      req_addr[i*AW +: AW] = a;
   endtask

   task automatic push(input int i, input logic [AW-1:0] a);
      exp_t e;
      e.who    = '0;
      e.who[i] = 1'b1;
      e.data   = mem[a[7:0]];
      sb.push_back(e);
   endtask

   // Wait (bounded) for the next rd_valid pulse; cycles = negedges waited
   task automatic wait_valid(output int cycles);
      cycles = 0;
      do begin
         @(negedge clock);
         cycles++;
      end while (rd_valid === '0 && cycles < 30);
      n_tests++;
      assert (rd_valid !== '0) else begin
         n_fail++;
         $error("FAIL rd_valid_timeout: observed %b after %0d cycles, expected a pulse", rd_valid, cycles);
      end
   endtask

   // Wait for a pulse, check its target, and let that requester drop its req
   task automatic take(input string tag, input logic [NR-1:0] exp_oh);
      int c;
      wait_valid(c);
      check(tag, 32'(rd_valid), 32'(exp_oh));
      req = req & ~rd_valid;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      for (int i = 0; i < 256; i++) mem[i] = 16'hF000 | 16'(i);
      data_b   = '0;
      req      = '0;
      req_addr = '0;
      reset_n  = 1'b0;

      // Reset state
      repeat (3) @(negedge clock);
      check("reset_grant", 32'(grant), 32'h0);
      check("reset_rd_valid", 32'(rd_valid), 32'h0);
      check("reset_rd_data", 32'(rd_data), 32'h0);
      check("reset_address_b", 32'(Address_B), 32'h0);
      reset_n = 1'b1;
      @(negedge clock);

      // Single read: requester 0, address 13, cycle-exact timing
      mem[13] = 16'h1234;
      set_req(0, 1'b1, 16'd13);
      push(0, 16'd13);
      @(negedge clock);
      check("single_grant_n", 32'(grant), 32'h1);
      check("single_addr_n", 32'(Address_B), 32'd13);
      check("single_valid_n", 32'(rd_valid), 32'h0);
      @(negedge clock);
      check("single_valid_n1", 32'(rd_valid), 32'h0);
      @(negedge clock);
      check("single_valid_n2", 32'(rd_valid), 32'h1);
      check("single_data_n2", 32'(rd_data), 32'h1234);
      set_req(0, 1'b0, 16'd13);
      @(negedge clock);
      check("single_valid_n3", 32'(rd_valid), 32'h0);
      check("single_grant_n3", 32'(grant), 32'h0);
      check("single_data_hold", 32'(rd_data), 32'h1234);
      @(negedge clock);
      check("single_idle_grant", 32'(grant), 32'h0);

      // Requester 2 alone, leaves the round-robin pointer at 3
      mem[20] = 16'h2020;
      set_req(2, 1'b1, 16'd20);
      push(2, 16'd20);
      take("ptr3_setup", 4'b0100);
      repeat (2) @(negedge clock);

      // Wrap: pointer at 3 with requests on 3 and 0
      mem[21] = 16'h3333;
      mem[22] = 16'h0A0A;
      set_req(3, 1'b1, 16'd21);
      set_req(0, 1'b1, 16'd22);
`ifdef RAM_ARB_FIXED_PRIORITY_EN
      push(0, 16'd22);
      push(3, 16'd21);
      take("wrap_first", 4'b0001);
      take("wrap_second", 4'b1000);
`else
      push(3, 16'd21);
      push(0, 16'd22);
      take("wrap_first", 4'b1000);
      take("wrap_second", 4'b0001);
`endif
      repeat (2) @(negedge clock);

      // Late request: requester 2 rises while requester 0 is in WAIT
      mem[40] = 16'h55AA;
      mem[30] = 16'hC0DE;
      set_req(0, 1'b1, 16'd40);
      push(0, 16'd40);
      @(negedge clock);
      check("late_grant0", 32'(grant), 32'h1);
      @(negedge clock);
      set_req(2, 1'b1, 16'd30);
      push(2, 16'd30);
      @(negedge clock);
      check("late_valid0", 32'(rd_valid), 32'h1);
      set_req(0, 1'b0, 16'd40);
      @(negedge clock);
      check("late_done_grant", 32'(grant), 32'h0);
      @(negedge clock);
      check("late_grant2", 32'(grant), 32'h4);
      check("late_addr2", 32'(Address_B), 32'd30);
      take("late_valid2", 4'b0100);
      repeat (2) @(negedge clock);

      // Reset mid-WAIT with requester 1 granted
      mem[14] = 16'hBEEF;
      set_req(1, 1'b1, 16'd14);
      @(negedge clock);
      check("rst_grant_addr", 32'(grant), 32'h2);
      @(negedge clock);
      check("rst_grant_wait", 32'(grant), 32'h2);
      #2 reset_n = 1'b0;
      #1;
      check("rst_async_grant", 32'(grant), 32'h0);
      check("rst_async_valid", 32'(rd_valid), 32'h0);
      check("rst_async_data", 32'(rd_data), 32'h0);
      check("rst_async_addr", 32'(Address_B), 32'h0);
      set_req(1, 1'b0, 16'd14);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         check("rst_no_valid", 32'(rd_valid), 32'h0);
      end

      // All four requesting continuously from a freshly reset pointer
      for (int k = 0; k < NR; k++) mem[13 + k] = 16'h000A + 16'(k);
      for (int k = 0; k < NR; k++) set_req(k, 1'b1, 16'(13 + k));
`ifdef RAM_ARB_FIXED_PRIORITY_EN
      seq5 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
      seq5 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
      for (int k = 0; k < 5; k++) begin
         for (int j = 0; j < NR; j++) begin
            if (seq5[k][j]) push(j, 16'(13 + j));
         end
      end
      for (int k = 0; k < 5; k++) begin
         wait_valid(c);
         if (k > 0) check("rr_spacing", 32'(c), 32'd4);
         check("rr_order", 32'(rd_valid), 32'(seq5[k]));
      end
      req = '0;
      repeat (3) @(negedge clock);

      // Requests 0 and 2 held continuously
      mem[50] = 16'h5050;
      mem[52] = 16'h5252;
      set_req(0, 1'b1, 16'd50);
      set_req(2, 1'b1, 16'd52);
`ifdef RAM_ARB_FIXED_PRIORITY_EN
      seq3 = '{4'b0001, 4'b0001, 4'b0001};
`else
      seq3 = '{4'b0100, 4'b0001, 4'b0100};
`endif
      for (int k = 0; k < 3; k++) begin
         if (seq3[k][0]) push(0, 16'd50);
         else push(2, 16'd52);
      end
      for (int k = 0; k < 3; k++) begin
         wait_valid(c);
         check("pair_order", 32'(rd_valid), 32'(seq3[k]));
         check("pair_grant", 32'(grant), 32'(seq3[k]));
      end
      req = '0;
      repeat (4) @(negedge clock);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
